mem_block_reader: RTL and testbench
===================================

Name: mem_block_reader

Overview:
- Read-side counterpart to the core's register/memory write path.
- Given a base address and a word count, sequentially reads a block from a single-port synchronous RAM (1-cycle read latency).
- Streams the words to a consumer over a valid/ready interface; a 2-entry skid FIFO absorbs backpressure so reads in flight are never lost.
- Sits between the shared data memory and a core's operand loader.

Parameters:
- DATA_WIDTH, 12, width of memory word and output data.
- ADDR_WIDTH, 8, memory address width; also the width of the length input.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- baseAddr  input  ADDR_WIDTH  first word address; captured when start is accepted.
- length  input  ADDR_WIDTH  number of words to read, 0..2^ADDR_WIDTH-1; captured with start.
- busy  output  1  high while a block transfer is in progress.
- done  output  1  one-cycle pulse when the transfer completes.
- memAddr  output  ADDR_WIDTH  RAM read address.
- memRdEn  output  1  RAM read enable.
- memData  input  DATA_WIDTH  RAM read data, valid the cycle after memRdEn.
- outData  output  DATA_WIDTH  streamed word (FIFO head).
- outValid  output  1  outData valid.
- outReady  input  1  consumer accepts when outValid & outReady.

Behaviour:
- Reset (rst=1 at a clock edge), registered values: state=IDLE, busy=0, done=0, memRdEn=0, memAddr=0, outValid=0, outData=0, FIFO empty, counters 0, in-flight flag 0.
- Reset mid-transfer aborts immediately. In-flight data is discarded and FIFO contents are dropped; no done pulse is produced.
- FSM states:
  - IDLE: on start, capture baseAddr and length. If length=0, go to DONE; else go to READ.
  - READ: issue reads until issued count == length, then go to DRAIN.
  - DRAIN: wait until in-flight=0, FIFO empty, and the last word is accepted, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in READ and DRAIN; 0 in IDLE and DONE.
- start is ignored when not in IDLE. start coincident with rst is ignored.
- Read issue in READ: memRdEn=1 in a cycle iff (fifoCount + inFlight − pop) < 2, where pop = outValid & outReady.
  - memAddr = baseAddr + issuedCount, modulo 2^ADDR_WIDTH. Address wraps 2^ADDR_WIDTH−1 → 0 with no error.
  - memAddr holds its last value when memRdEn=0.
- Return path: the cycle after memRdEn, memData is pushed into the FIFO. The credit rule guarantees the push never overflows.
- Simultaneous push and pop on a full FIFO is not reachable. Push and pop with count=1 keeps count=1.
- Latency: start accepted at edge 0 → memRdEn in cycle 1 → memData in cycle 2 → outValid in cycle 3.
- Throughput: 1 word/cycle while outReady is held high.
- Backpressure: with outReady low, at most 2 words are buffered and memRdEn stays low. outData and outValid stay stable until accepted.
- Ordering: words leave in ascending (wrapped) address order, with no duplicates or drops.
- done: asserted in the cycle after the last handshake (or in cycle 1 after start when length=0).

Decomposition:
- Package mem_reader_pkg: state enum (IDLE, READ, DRAIN, DONE) and the constant FIFO_DEPTH=2.
- Sub-module skid_fifo:
  - Parameters: DATA_WIDTH, depth 2.
  - Ports: push/pop/count/head, same clk/rst.
- Top holds the FSM, address/issue counters, and the in-flight flag.

Test Plan:
- Basic, outReady=1, start with baseAddr=10, length=4, RAM[a]=a+100 → outValid in cycles 3..6 with outData 110,111,112,113; done pulse cycle 7; busy 1..6.
- Wrap: baseAddr=254, length=4 → memAddr sequence 254,255,0,1; outData RAM values in that order; done once.
- Backpressure: length=5, outReady=0 for cycles 3..10, then 1 → memRdEn stops after 2 reads; outData=first word held stable; all 5 words delivered in order; no loss.
- Zero length: start with length=0 → no memRdEn; done=1 in cycle 1; busy never high.
- Start ignored / reset abort: second start with other baseAddr during transfer → ignored. rst=1 mid-transfer → next cycle outValid=0, busy=0, no done. A new start afterwards runs cleanly.
- Random outReady (50%) over length=200 → scoreboard matches RAM contents exactly; FIFO count never exceeds 2.

Source files
------------

// File: rtl/mem_reader_pkg.sv
// Shared types and constants for the block reader and its return-path skid FIFO.
package mem_reader_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/mem_block_reader_skid_fifo.sv
// Two-entry skid FIFO catching RAM read data; head is combinational and reads zero when empty.
// Pushes are credit-limited upstream, so a push never arrives while full without a pop.
module skid_fifo
  import mem_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_ok   = pop && (count_q != 2'd0);
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/mem_block_reader.sv
// Reads length words from base address of a 1-cycle-latency RAM and streams them out in order.
// start->first outValid is 3 cycles; reads are throttled so at most 2 words are ever buffered.
module mem_block_reader
  import mem_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRdEn,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic                  rd_en;
  logic [2:0]            occ;

  assign pop      = outValid & outReady;
  assign outValid = (fifo_count != 2'd0);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    rd_en    = 1'b0;
    // Words buffered or in flight after this cycle's pop; a new read needs a free slot.
    occ      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = baseAddr;
          len_d    = length;
          issued_d = '0;
          state_d  = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (occ < 3'd2) begin
          rd_en    = 1'b1;
          addr_d   = base_q + issued_q;
          issued_d = issued_q + 1'b1;
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the last word is handed off so done lands one cycle after it.
        if (!inflight_q && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
    end
  end

  assign memRdEn = rd_en;
  assign memAddr = addr_d;
  assign busy    = (state_q == READ) || (state_q == DRAIN);
  assign done    = (state_q == DONE);

  skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_dat (memData),
    .pop      (pop),
    .count    (fifo_count),
    .head     (outData)
  );

endmodule

// File: tb/tb_mem_block_reader.sv
// Scoreboarded bench for mem_block_reader with a behavioural RAM and expected address/data queues.
module tb_mem_block_reader;
  localparam int DW = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done, memRdEn, outValid;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData = '0;
  logic [DW-1:0] outData;
  logic          outReady = 1'b1;

  always #5 clk = ~clk;

  mem_block_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .length(length),
    .busy(busy), .done(done), .memAddr(memAddr), .memRdEn(memRdEn), .memData(memData),
    .outData(outData), .outValid(outValid), .outReady(outReady)
  );

  logic [DW-1:0] ram [256];
  always @(posedge clk) if (memRdEn) memData <= ram[memAddr];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;
  int outstanding = 0;
  logic [DW-1:0] exp_dat_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every read address and every accepted word is checked against the queues.
  always @(negedge clk) begin
    if (rst) begin
      exp_dat_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", int'(outValid), 1);
        chk("hold_data", int'(outData), int'(data_prev));
      end
      if (memRdEn) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %0d, no read expected (t=%0t)", memAddr, $time);
        end else chk("rd_addr", int'(memAddr), int'(exp_addr_q.pop_front()));
        outstanding++;
      end
      if (outValid && outReady) begin
        if (exp_dat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: data %0d, no word expected (t=%0t)", outData, $time);
        end else chk("out_data", int'(outData), int'(exp_dat_q.pop_front()));
        outstanding--;
      end
      if (memRdEn) chk("buffered_le_2", outstanding, (outstanding <= 2) ? outstanding : 2);
      if (done) done_seen++;
      stall_prev = outValid && !outReady;
      data_prev  = outData;
    end
  end

  // Called at posedge+1; returns at cycle 1 (+1) after the accepting edge.
  task automatic start_block(input logic [AW-1:0] b, input logic [AW-1:0] n);
    logic [AW-1:0] a;
    baseAddr = b;
    length   = n;
    start    = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      exp_addr_q.push_back(a);
      exp_dat_q.push_back(ram[a]);
    end
    done_exp++;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int rand_ready, input int inject_at);
    bit got = 1'b0;
    for (int c = 1; c <= budget && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
      if (rand_ready != 0) outReady = 1'($urandom_range(0, 1));
      if (c == inject_at) begin
        start    = 1'b1;
        baseAddr = baseAddr + 8'd77;
        length   = 8'd3;
      end else start = 1'b0;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    outReady = 1'b1;
    chk("done_count", done_seen, done_exp);
    chk("queues_empty", exp_dat_q.size() + exp_addr_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    logic [AW-1:0] rb;
    for (int i = 0; i < 256; i++) ram[i] = DW'(i + 100);

    // Reset, with a start that must be ignored because rst is high.
    start = 1'b1; baseAddr = 8'd5; length = 8'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rden", int'(memRdEn), 0);
    chk("rst_addr", int'(memAddr), 0);
    chk("rst_valid", int'(outValid), 0);
    chk("rst_data", int'(outData), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", int'(busy), 0);
      @(posedge clk); #1;
    end

    // Basic cycle-accurate timing.
    start_block(8'd10, 8'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("basic_valid_c%0d", c), int'(outValid), int'(c >= 3 && c <= 6));
      chk($sformatf("basic_busy_c%0d", c), int'(busy), int'(c <= 6));
      chk($sformatf("basic_done_c%0d", c), int'(done), int'(c == 7));
      chk($sformatf("basic_rden_c%0d", c), int'(memRdEn), int'(c <= 4));
      @(posedge clk); #1;
    end
    chk("basic_done_count", done_seen, done_exp);

    // Zero length.
    start_block(8'd33, 8'd0);
    @(negedge clk);
    chk("zero_done_c1", int'(done), 1);
    chk("zero_busy_c1", int'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_c2", int'(done), 0);
    @(posedge clk); #1;
    chk("zero_done_count", done_seen, done_exp);

    // Address wrap.
    start_block(8'd254, 8'd4);
    wait_done(50, 0, 0);

    // Backpressure: consumer stalls through cycle 10.
    outReady = 1'b0;
    start_block(8'd40, 8'd5);
    nrd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (memRdEn) nrd++;
      if (c == 3 || c == 10) chk($sformatf("bp_head_c%0d", c), int'(outData), int'(ram[40]));
      if (c == 10) chk("bp_valid", int'(outValid), 1);
      @(posedge clk); #1;
    end
    chk("bp_reads", nrd, 2);
    outReady = 1'b1;
    wait_done(50, 0, 0);

    // Reset mid-transfer aborts; a fresh start afterwards runs cleanly.
    start_block(8'd50, 8'd20);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    done_exp--;
    @(negedge clk);
    chk("abort_valid", int'(outValid), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (30) begin @(posedge clk); #1; end
    chk("abort_no_done", done_seen, done_exp);
    start_block(8'd100, 8'd8);
    wait_done(60, 0, 0);

    // Random contents, random consumer, and a start injected mid-transfer.
    for (int i = 0; i < 256; i++) ram[i] = DW'($urandom_range(0, 4095));
    rb = AW'($urandom_range(0, 255));
    start_block(rb, 8'd200);
    wait_done(3000, 1, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
